// File: rtl/mem_arbiter.sv
// Two-requester (CPU / debug host) arbiter for a single-port data memory.
// Combinational grant, starvation guard for debug, debug lock, one-cycle read return routing.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              dbg_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic {
        ARB,
        DBG_LOCKED
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] starve_nxt;
    logic             locked;
    logic             starve_hit;
    logic             rd_cpu;
    logic             rd_dbg;

    // Lock ownership ends in the same cycle dbg_lock drops, so the CPU can win that cycle.
    always_comb begin
        state_nxt  = state;
        cpu_gnt    = 1'b0;
        dbg_gnt    = 1'b0;
        locked     = (state == DBG_LOCKED) && dbg_lock;
        starve_hit = (starve_cnt == CNT_W'(STARVE_MAX));
        if (!rst) begin
            if (locked) begin
                dbg_gnt = dbg_req;
            end else if (cpu_req && !(starve_hit && dbg_req)) begin
                cpu_gnt = 1'b1;
            end else begin
                dbg_gnt = dbg_req;
            end
        end
        if (state == DBG_LOCKED && !dbg_lock) begin
            state_nxt = ARB;
        end
        if (dbg_gnt && dbg_lock) begin
            state_nxt = DBG_LOCKED;
        end
    end

    // Saturating count of consecutive denied debug cycles.
    always_comb begin
        starve_nxt = '0;
        if (dbg_req && !dbg_gnt) begin
            starve_nxt = starve_hit ? starve_cnt : starve_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB;
            starve_cnt <= '0;
            rd_cpu     <= 1'b0;
            rd_dbg     <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            rd_cpu     <= cpu_gnt && !cpu_we;
            rd_dbg     <= dbg_gnt && !dbg_we;
        end
    end

    // Memory returns read data one cycle after the strobe; route it to the recorded owner.
    assign cpu_stall  = cpu_req && !cpu_gnt && !rst;
    assign cpu_rvalid = rd_cpu;
    assign dbg_rvalid = rd_dbg;
    assign cpu_rdata  = rd_cpu ? mem_rdata : '0;
    assign dbg_rdata  = rd_dbg ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Table-driven bench for mem_arbiter with a read-return scoreboard and a simple memory model.
module tb_mem_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, mem_wdata, mem_rdata, cpu_rdata, dbg_rdata;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_we;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          rst;
        logic          cr;
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          dr;
        logic          dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic          lk;
        logic          e_cg;
        logic          e_dg;
    } vec_t;

    typedef struct {
        int            idx;
        logic          is_dbg;
        logic [DW-1:0] data;
    } sb_t;

    vec_t vec[26];
    sb_t  sb[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_lock(dbg_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return (a == AW'(3)) ? 32'hDEADBEEF : (32'hA500_0000 | DW'(a));
    endfunction

    // Synchronous-read memory model.
    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
    end

    function automatic vec_t mk(input logic r, cr, cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                                input logic dr, dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                                input logic lk, ecg, edg);
        vec_t v;
        v.rst = r; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.lk = lk;
        v.e_cg = ecg; v.e_dg = edg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        dbg_req = v.dr; dbg_we = v.dw; dbg_addr = v.da; dbg_wdata = v.dd; dbg_lock = v.lk;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_lock = 0;
    endtask

    initial begin
        vec_t          v;
        sb_t           e;
        logic          e_en, e_we, e_crv, e_drv;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd, e_crd, e_drd;

        rst = 1'b1;
        idle();

        vec[0]  = mk(1, 1,0,3,0,            1,0,2,0, 0, 0,0);
        vec[1]  = mk(0, 1,0,3,0,            0,0,0,0, 0, 1,0);
        vec[2]  = mk(0, 0,0,0,0,            0,0,0,0, 0, 0,0);
        vec[3]  = mk(0, 1,1,7,32'h12345678, 0,0,0,0, 0, 1,0);
        vec[4]  = mk(0, 0,0,0,0,            0,0,0,0, 0, 0,0);
        vec[5]  = mk(0, 1,0,1,0,            0,0,0,0, 0, 1,0);
        vec[6]  = mk(0, 0,0,0,0,            1,0,2,0, 0, 0,1);
        vec[7]  = mk(0, 0,0,0,0,            0,0,0,0, 0, 0,0);
        for (int i = 8; i < 12; i++) vec[i] = mk(0, 1,0,4,0, 1,0,5,0, 0, 1,0);
        vec[12] = mk(0, 1,0,4,0,            1,0,5,0, 0, 0,1);
        vec[13] = mk(0, 1,0,4,0,            1,0,5,0, 0, 1,0);
        vec[14] = mk(0, 0,0,0,0,            0,0,0,0, 0, 0,0);
        vec[15] = mk(0, 0,0,0,0,            1,0,9,0, 1, 0,1);
        vec[16] = mk(0, 1,0,4,0,            0,0,0,0, 1, 0,0);
        vec[17] = mk(0, 1,0,4,0,            1,1,9,32'h0BADF00D, 1, 0,1);
        vec[18] = mk(0, 1,0,4,0,            1,0,9,0, 1, 0,1);
        vec[19] = mk(0, 1,0,4,0,            1,0,9,0, 0, 1,0);
        vec[20] = mk(0, 0,0,0,0,            0,0,0,0, 0, 0,0);
        vec[21] = mk(0, 1,0,3,0,            0,0,0,0, 0, 1,0);
        vec[22] = mk(1, 1,0,3,0,            1,0,2,0, 0, 0,0);
        vec[23] = mk(0, 1,0,6,0,            0,0,0,0, 0, 1,0);
        vec[24] = mk(0, 0,0,0,0,            0,0,0,0, 0, 0,0);
        vec[25] = mk(0, 0,0,0,0,            0,0,0,0, 0, 0,0);

        for (int k = 0; k < 26; k++) begin
            v = vec[k];
            @(posedge clk);
            #1;
            drive(v);
            if (v.rst) sb.delete();
            if (!v.rst && v.e_cg && !v.cw) sb.push_back('{k, 1'b0, mem_val(v.ca)});
            if (!v.rst && v.e_dg && !v.dw) sb.push_back('{k, 1'b1, mem_val(v.da)});

            e_en = v.e_cg || v.e_dg;
            e_we = v.e_cg ? v.cw : (v.e_dg ? v.dw : 1'b0);
            e_addr = v.e_cg ? v.ca : (v.e_dg ? v.da : '0);
            e_wd = v.e_cg ? v.cd : (v.e_dg ? v.dd : '0);
            e_crv = 0; e_drv = 0; e_crd = '0; e_drd = '0;
            if (sb.size() > 0 && sb[0].idx == k - 1) begin
                e = sb.pop_front();
                if (e.is_dbg) begin e_drv = 1; e_drd = e.data; end
                else begin e_crv = 1; e_crd = e.data; end
            end

            @(negedge clk);
            chk($sformatf("v%0d cpu_gnt", k), DW'(cpu_gnt), DW'(v.e_cg));
            chk($sformatf("v%0d dbg_gnt", k), DW'(dbg_gnt), DW'(v.e_dg));
            chk($sformatf("v%0d cpu_stall", k), DW'(cpu_stall), DW'(v.cr && !v.e_cg && !v.rst));
            chk($sformatf("v%0d mem_en", k), DW'(mem_en), DW'(e_en));
            chk($sformatf("v%0d mem_we", k), DW'(mem_we), DW'(e_we));
            chk($sformatf("v%0d mem_addr", k), DW'(mem_addr), DW'(e_addr));
            chk($sformatf("v%0d mem_wdata", k), mem_wdata, e_wd);
            chk($sformatf("v%0d cpu_rvalid", k), DW'(cpu_rvalid), DW'(e_crv));
            chk($sformatf("v%0d cpu_rdata", k), cpu_rdata, e_crd);
            chk($sformatf("v%0d dbg_rvalid", k), DW'(dbg_rvalid), DW'(e_drv));
            chk($sformatf("v%0d dbg_rdata", k), dbg_rdata, e_drd);
        end
        chk("sb drained", DW'(sb.size()), DW'(0));

        // Reset landing mid-cycle right after a read return kills it immediately.
        @(posedge clk);
        #1;
        idle();
        cpu_req = 1; cpu_addr = AW'(3);
        @(negedge clk);
        chk("seq cpu_gnt", DW'(cpu_gnt), DW'(1));
        @(posedge clk);
        #1;
        chk("seq rvalid before rst", DW'(cpu_rvalid), DW'(1));
        chk("seq rdata before rst", cpu_rdata, 32'hDEADBEEF);
        cpu_addr = AW'(5);
        #1 rst = 1'b1;
        #1;
        chk("seq rvalid in rst", DW'(cpu_rvalid), DW'(0));
        chk("seq rdata in rst", cpu_rdata, DW'(0));
        chk("seq gnt in rst", DW'(cpu_gnt), DW'(0));
        chk("seq mem_en in rst", DW'(mem_en), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("seq gnt after rst", DW'(cpu_gnt), DW'(1));
        chk("seq rvalid after rst", DW'(cpu_rvalid), DW'(0));
        @(posedge clk);
        #1;
        idle();
        chk("seq rvalid addr5", DW'(cpu_rvalid), DW'(1));
        chk("seq rdata addr5", cpu_rdata, mem_val(AW'(5)));
        @(posedge clk);
        #1;
        chk("seq no spurious rvalid", DW'(cpu_rvalid), DW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
